// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between icache and dcache, one line transaction at a time.
// Latency: command one cycle after grant; resp is forwarded combinationally to the owner only.
module pmem_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_pmem_read,
    input  logic              icache_pmem_write,
    input  logic [ADDR_W-1:0] icache_pmem_address,
    input  logic [LINE_W-1:0] icache_pmem_wdata,
    output logic              icache_pmem_resp,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [ADDR_W-1:0] dcache_pmem_address,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic              dcache_pmem_resp,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic [1:0]        arb_owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } state_t;

    state_t            state_q;
    logic              last_grant_q;   // 0: icache served last, 1: dcache served last
    logic              pmem_read_q;
    logic              pmem_write_q;
    logic [ADDR_W-1:0] pmem_address_q;
    logic [LINE_W-1:0] pmem_wdata_q;
    logic [1:0]        arb_owner_q;

    logic i_req;
    logic d_req;
    logic pick_dcache;

    always_comb begin
        i_req       = icache_pmem_read | icache_pmem_write;
        d_req       = dcache_pmem_read | dcache_pmem_write;
        // On a tie, fixed priority favours dcache; round robin favours whoever was not served last.
        pick_dcache = d_req & (~i_req | ~ROUND_ROBIN | ~last_grant_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            arb_owner_q    <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    // A write wins over a simultaneous read from the same requester.
                    if (pick_dcache) begin
                        state_q        <= SERVE_D;
                        arb_owner_q    <= 2'b10;
                        pmem_write_q   <= dcache_pmem_write;
                        pmem_read_q    <= dcache_pmem_read & ~dcache_pmem_write;
                        pmem_address_q <= dcache_pmem_address;
                        pmem_wdata_q   <= dcache_pmem_wdata;
                    end else if (i_req) begin
                        state_q        <= SERVE_I;
                        arb_owner_q    <= 2'b01;
                        pmem_write_q   <= icache_pmem_write;
                        pmem_read_q    <= icache_pmem_read & ~icache_pmem_write;
                        pmem_address_q <= icache_pmem_address;
                        pmem_wdata_q   <= icache_pmem_wdata;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state_q      <= IDLE;
                        arb_owner_q  <= 2'b00;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        last_grant_q <= (state_q == SERVE_D);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign icache_pmem_resp  = pmem_resp & (state_q == SERVE_I);
    assign dcache_pmem_resp  = pmem_resp & (state_q == SERVE_D);
    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign arb_owner    = arb_owner_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: a round-robin and a fixed-priority instance run in lockstep on shared stimulus.
module tb_pmem_arbiter;

    logic         clk;
    logic         rst;
    logic         icache_pmem_read, icache_pmem_write;
    logic [15:0]  icache_pmem_address;
    logic [127:0] icache_pmem_wdata;
    logic         dcache_pmem_read, dcache_pmem_write;
    logic [15:0]  dcache_pmem_address;
    logic [127:0] dcache_pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    logic         icache_pmem_resp, dcache_pmem_resp;
    logic [127:0] icache_pmem_rdata, dcache_pmem_rdata;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [1:0]   arb_owner;

    logic         r0_icache_pmem_resp, r0_dcache_pmem_resp;
    logic [127:0] r0_icache_pmem_rdata, r0_dcache_pmem_rdata;
    logic         r0_pmem_read, r0_pmem_write;
    logic [15:0]  r0_pmem_address;
    logic [127:0] r0_pmem_wdata;
    logic [1:0]   r0_arb_owner;

    pmem_arbiter #(.ROUND_ROBIN(1'b1), .ADDR_W(16), .LINE_W(128)) dut (
        .clk(clk), .rst(rst),
        .icache_pmem_read(icache_pmem_read), .icache_pmem_write(icache_pmem_write),
        .icache_pmem_address(icache_pmem_address), .icache_pmem_wdata(icache_pmem_wdata),
        .icache_pmem_resp(icache_pmem_resp), .icache_pmem_rdata(icache_pmem_rdata),
        .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
        .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
        .dcache_pmem_resp(dcache_pmem_resp), .dcache_pmem_rdata(dcache_pmem_rdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .arb_owner(arb_owner)
    );

    pmem_arbiter #(.ROUND_ROBIN(1'b0), .ADDR_W(16), .LINE_W(128)) dut_fixed (
        .clk(clk), .rst(rst),
        .icache_pmem_read(icache_pmem_read), .icache_pmem_write(icache_pmem_write),
        .icache_pmem_address(icache_pmem_address), .icache_pmem_wdata(icache_pmem_wdata),
        .icache_pmem_resp(r0_icache_pmem_resp), .icache_pmem_rdata(r0_icache_pmem_rdata),
        .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
        .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
        .dcache_pmem_resp(r0_dcache_pmem_resp), .dcache_pmem_rdata(r0_dcache_pmem_rdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .pmem_read(r0_pmem_read), .pmem_write(r0_pmem_write),
        .pmem_address(r0_pmem_address), .pmem_wdata(r0_pmem_wdata),
        .arb_owner(r0_arb_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         i_rd;
        logic         i_wr;
        logic [15:0]  i_addr;
        logic [127:0] i_wd;
        logic         d_rd;
        logic         d_wr;
        logic [15:0]  d_addr;
        logic [127:0] d_wd;
        logic [1:0]   e_own;
        logic         e_rd;
        logic         e_wr;
        logic [15:0]  e_addr;
        logic [127:0] e_wd;
        int           lat;
        logic [127:0] rdata;
    } vec_t;

    typedef struct {
        logic [1:0]   own;
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        icache_pmem_read  = 1'b0;
        icache_pmem_write = 1'b0;
        dcache_pmem_read  = 1'b0;
        dcache_pmem_write = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] own, input logic rd, input logic wr,
                            input logic [15:0] addr, input logic [127:0] wd);
        exp_t e;
        e.own = own; e.rd = rd; e.wr = wr; e.addr = addr; e.wd = wd;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got command owner %0h, expected none", arb_owner);
        end else begin
            e = sb.pop_front();
            chk("owner", 128'(arb_owner), 128'(e.own));
            chk("pmem_read", 128'(pmem_read), 128'(e.rd));
            chk("pmem_write", 128'(pmem_write), 128'(e.wr));
            chk("pmem_address", 128'(pmem_address), 128'(e.addr));
            chk("pmem_wdata", pmem_wdata, e.wd);
        end
    endtask

    task automatic run_vec(input vec_t v);
        icache_pmem_read    = v.i_rd;
        icache_pmem_write   = v.i_wr;
        icache_pmem_address = v.i_addr;
        icache_pmem_wdata   = v.i_wd;
        dcache_pmem_read    = v.d_rd;
        dcache_pmem_write   = v.d_wr;
        dcache_pmem_address = v.d_addr;
        dcache_pmem_wdata   = v.d_wd;
        push_exp(v.e_own, v.e_rd, v.e_wr, v.e_addr, v.e_wd);
        tick();
        chk("grant_latency", 128'(pmem_read | pmem_write), 128'(1));
        pop_cmp();
        repeat (v.lat) begin
            tick();
            chk("no_early_resp", 128'({icache_pmem_resp, dcache_pmem_resp}), 128'(0));
        end
        pmem_resp  = 1'b1;
        pmem_rdata = v.rdata;
        #1;
        chk("icache_resp", 128'(icache_pmem_resp), 128'(v.e_own == 2'b01));
        chk("dcache_resp", 128'(dcache_pmem_resp), 128'(v.e_own == 2'b10));
        chk("owner_rdata", (v.e_own == 2'b01) ? icache_pmem_rdata : dcache_pmem_rdata, v.rdata);
        tick();
        pmem_resp = 1'b0;
        drop_reqs();
        chk("owner_idle", 128'(arb_owner), 128'(0));
        chk("cmd_clear", 128'({pmem_read, pmem_write}), 128'(0));
        chk("resp_pulse_end", 128'({icache_pmem_resp, dcache_pmem_resp}), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        vec_t fresh;
        tbl[0] = '{1'b1, 1'b0, 16'h1230, '0, 1'b0, 1'b0, 16'h0, '0,
                   2'b01, 1'b1, 1'b0, 16'h1230, '0, 3, {32{4'hA}}};
        tbl[1] = '{1'b0, 1'b0, 16'h0, '0, 1'b0, 1'b1, 16'h4560, 128'h0123456789ABCDEF0123456789ABCDEF,
                   2'b10, 1'b0, 1'b1, 16'h4560, 128'h0123456789ABCDEF0123456789ABCDEF, 2, '0};
        tbl[2] = '{1'b0, 1'b0, 16'h0, '0, 1'b1, 1'b1, 16'h7770, {16{8'h5A}},
                   2'b10, 1'b0, 1'b1, 16'h7770, {16{8'h5A}}, 1, {32{4'h3}}};
        tbl[3] = '{1'b0, 1'b0, 16'h0, '0, 1'b1, 1'b0, 16'hFFF0, {16{8'hC3}},
                   2'b10, 1'b1, 1'b0, 16'hFFF0, {16{8'hC3}}, 0, {32{4'h9}}};
        tbl[4] = '{1'b0, 1'b1, 16'h0040, {16{8'h55}}, 1'b0, 1'b0, 16'h0, '0,
                   2'b01, 1'b0, 1'b1, 16'h0040, {16{8'h55}}, 1, '0};

        rst = 1'b1;
        drop_reqs();
        icache_pmem_address = '0; icache_pmem_wdata = '0;
        dcache_pmem_address = '0; dcache_pmem_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        tick();
        tick();
        chk("reset_owner", 128'(arb_owner), 128'(0));
        chk("reset_cmd", 128'({pmem_read, pmem_write}), 128'(0));
        chk("reset_addr", 128'(pmem_address), 128'(0));
        chk("reset_wdata", pmem_wdata, 128'(0));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Both caches hold reads continuously: round robin alternates, fixed priority always picks dcache.
        icache_pmem_read = 1'b1; icache_pmem_address = 16'h1000; icache_pmem_wdata = {16{8'h11}};
        dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h2000; dcache_pmem_wdata = {16{8'h22}};
        push_exp(2'b10, 1'b1, 1'b0, 16'h2000, {16{8'h22}});
        push_exp(2'b01, 1'b1, 1'b0, 16'h1000, {16{8'h11}});
        push_exp(2'b10, 1'b1, 1'b0, 16'h2000, {16{8'h22}});
        push_exp(2'b01, 1'b1, 1'b0, 16'h1000, {16{8'h11}});
        for (int k = 0; k < 4; k++) begin
            logic [1:0] own;
            tick();
            own = arb_owner;
            pop_cmp();
            chk("fixed_owner", 128'(r0_arb_owner), 128'(2'b10));
            chk("fixed_addr", 128'(r0_pmem_address), 128'(16'h2000));
            chk("fixed_cmd", 128'({r0_pmem_read, r0_pmem_write}), 128'(2'b10));
            chk("fixed_wdata", r0_pmem_wdata, {16{8'h22}});
            tick();
            pmem_resp  = 1'b1;
            pmem_rdata = {4{32'hC0DE0000 + 32'(k)}};
            #1;
            chk("rr_icache_resp", 128'(icache_pmem_resp), 128'(own == 2'b01));
            chk("rr_dcache_resp", 128'(dcache_pmem_resp), 128'(own == 2'b10));
            chk("fixed_resp", 128'({r0_icache_pmem_resp, r0_dcache_pmem_resp}), 128'(2'b01));
            chk("fixed_rdata", r0_dcache_pmem_rdata, {4{32'hC0DE0000 + 32'(k)}});
            chk("fixed_irdata", r0_icache_pmem_rdata, {4{32'hC0DE0000 + 32'(k)}});
            tick();
            pmem_resp = 1'b0;
        end
        drop_reqs();
        tick();

        // Requester changes its inputs mid-transaction; latched command must not move.
        icache_pmem_read = 1'b1; icache_pmem_address = 16'h3330; icache_pmem_wdata = {16{8'h77}};
        push_exp(2'b01, 1'b1, 1'b0, 16'h3330, {16{8'h77}});
        tick();
        pop_cmp();
        icache_pmem_address = 16'hFFFF;
        icache_pmem_wdata   = {16{8'hEE}};
        repeat (3) tick();
        chk("addr_hold", 128'(pmem_address), 128'(16'h3330));
        chk("wdata_hold", pmem_wdata, {16{8'h77}});
        pmem_resp = 1'b1; pmem_rdata = {32{4'h6}};
        #1;
        chk("hold_resp", 128'({icache_pmem_resp, dcache_pmem_resp}), 128'(2'b10));
        tick();
        pmem_resp = 1'b0;
        drop_reqs();
        tick();

        // Spurious resp while idle.
        pmem_resp = 1'b1;
        #1;
        chk("spurious_resp", 128'({icache_pmem_resp, dcache_pmem_resp}), 128'(0));
        tick();
        pmem_resp = 1'b0;
        chk("spurious_owner", 128'(arb_owner), 128'(0));
        chk("spurious_cmd", 128'({pmem_read, pmem_write}), 128'(0));

        // Reset in the middle of a dcache transaction.
        dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h5550; dcache_pmem_wdata = {16{8'h99}};
        tick();
        chk("pre_reset_owner", 128'(arb_owner), 128'(2'b10));
        chk("pre_reset_read", 128'(pmem_read), 128'(1));
        #3;
        rst = 1'b1;
        #1;
        chk("async_owner", 128'(arb_owner), 128'(0));
        chk("async_cmd", 128'({pmem_read, pmem_write}), 128'(0));
        chk("async_addr", 128'(pmem_address), 128'(0));
        chk("async_wdata", pmem_wdata, 128'(0));
        chk("async_resp", 128'({icache_pmem_resp, dcache_pmem_resp}), 128'(0));
        tick();
        rst = 1'b0;
        drop_reqs();
        pmem_resp = 1'b1;
        #1;
        chk("post_reset_resp", 128'({icache_pmem_resp, dcache_pmem_resp}), 128'(0));
        tick();
        pmem_resp = 1'b0;
        chk("post_reset_owner", 128'(arb_owner), 128'(0));

        fresh = '{1'b1, 1'b0, 16'h0ABC, '0, 1'b0, 1'b0, 16'h0, '0,
                  2'b01, 1'b1, 1'b0, 16'h0ABC, '0, 1, {32{4'hF}}};
        run_vec(fresh);

        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
